// File: rtl/module_cla_arbiter_if.sv
// Request/result bus between two requesters, one consumer and the shared-adder arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/consumer side.
interface module_cla_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_pi;
    logic [WIDTH-1:0] a0_pi;
    logic [WIDTH-1:0] b0_pi;
    logic             req1_pi;
    logic [WIDTH-1:0] a1_pi;
    logic [WIDTH-1:0] b1_pi;
    logic             ack_pi;
    logic             gnt0_po;
    logic             gnt1_po;
    logic             busy_po;
    logic             valid_po;
    logic             id_po;
    logic [WIDTH-1:0] sum_po;
    logic             carry_po;

    modport slave (
        input  req0_pi, a0_pi, b0_pi,
        input  req1_pi, a1_pi, b1_pi,
        input  ack_pi,
        output gnt0_po, gnt1_po, busy_po, valid_po, id_po, sum_po, carry_po
    );

    modport master (
        output req0_pi, a0_pi, b0_pi,
        output req1_pi, a1_pi, b1_pi,
        output ack_pi,
        input  gnt0_po, gnt1_po, busy_po, valid_po, id_po, sum_po, carry_po
    );
endinterface

// File: rtl/module_cla_arbiter.sv
// Round-robin arbiter sharing one carry-lookahead adder between two requesters.
// The adder has no carry-out port; the controller rebuilds the carry from the operand
// MSBs and the sum MSB.

// Carry-lookahead adder, sum only (the final carry is not exported).
module module_cla_8bits #(
    parameter int WIDTH2 = 8
) (
    input  logic [WIDTH2-1:0] a_pi,
    input  logic [WIDTH2-1:0] b_pi,
    output logic [WIDTH2-1:0] result_po
);
    logic [WIDTH2-1:0] gen;
    logic [WIDTH2-1:0] prop;
    logic [WIDTH2-1:0] carry;

    assign gen      = a_pi & b_pi;
    assign prop     = a_pi ^ b_pi;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH2 - 1; i++) begin : g_carry
        assign carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end

    assign result_po = prop ^ carry;
endmodule

module module_cla_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_pi,
    input  logic                 rst_n_pi,
    module_cla_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] adder_sum;
    logic             pick;

    module_cla_8bits #(
        .WIDTH2 (WIDTH)
    ) u_adder (
        .a_pi      (a_q),
        .b_pi      (b_q),
        .result_po (adder_sum)
    );

    // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        pick = ~last_q;
        if (bus.req0_pi && !bus.req1_pi) begin
            pick = 1'b0;
        end else if (bus.req1_pi && !bus.req0_pi) begin
            pick = 1'b1;
        end
    end

    // Next-state and next-output logic for the grant/compute/hold sequence.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = busy_q;
        valid_d = valid_q;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_pi || bus.req1_pi) begin
                    a_d     = pick ? bus.a1_pi : bus.a0_pi;
                    b_d     = pick ? bus.b1_pi : bus.b0_pi;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    id_d    = pick;
                    last_d  = pick;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = adder_sum;
                carry_d = (a_q[WIDTH-1] & b_q[WIDTH-1])
                        | ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) & ~adder_sum[WIDTH-1]);
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.ack_pi) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Register state and all outputs; reset discards any in-flight operation.
    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.gnt0_po  = gnt0_q;
    assign bus.gnt1_po  = gnt1_q;
    assign bus.busy_po  = busy_q;
    assign bus.valid_po = valid_q;
    assign bus.id_po    = id_q;
    assign bus.sum_po   = sum_q;
    assign bus.carry_po = carry_q;
endmodule

// File: tb/tb_module_cla_arbiter.sv
// Bench for module_cla_arbiter: directed scenarios with literal expectations, then
// protocol-respecting random traffic, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_module_cla_arbiter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 1'b0;

    module_cla_arbiter_if #(.WIDTH(WIDTH)) bus ();

    module_cla_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_pi   (clk),
        .rst_n_pi (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: phase 0 = waiting, 1 = computing, 2 = holding a result.
    int               m_phase = 0;
    bit               m_last = 1'b1;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    bit               m_gnt0 = 1'b0;
    bit               m_gnt1 = 1'b0;
    bit               m_valid = 1'b0;
    bit               m_id = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    bit               m_carry = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the winner is a lone requester, or on a tie the one not served last;
    // the result is plain (WIDTH+1)-bit addition.
    always @(posedge clk) begin : model
        logic [WIDTH:0] full;
        bit             w;
        if (!rst_n) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_gnt0  <= 1'b0;
            m_gnt1  <= 1'b0;
            m_valid <= 1'b0;
            m_id    <= 1'b0;
            m_sum   <= '0;
            m_carry <= 1'b0;
        end else begin
            m_gnt0 <= 1'b0;
            m_gnt1 <= 1'b0;
            if (m_phase == 0) begin
                if (bus.req0_pi || bus.req1_pi) begin
                    if (bus.req0_pi && bus.req1_pi) w = ~m_last;
                    else                            w = bus.req1_pi;
                    m_a     <= w ? bus.a1_pi : bus.a0_pi;
                    m_b     <= w ? bus.b1_pi : bus.b0_pi;
                    m_gnt0  <= ~w;
                    m_gnt1  <= w;
                    m_id    <= w;
                    m_last  <= w;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                full    = {1'b0, m_a} + {1'b0, m_b};
                m_sum   <= full[WIDTH-1:0];
                m_carry <= full[WIDTH];
                m_valid <= 1'b1;
                m_phase <= 2;
            end else if (bus.ack_pi) begin
                m_valid <= 1'b0;
                m_phase <= 0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("cmp_gnt0",  bus.gnt0_po,  m_gnt0);
            check_output("cmp_gnt1",  bus.gnt1_po,  m_gnt1);
            check_output("cmp_busy",  bus.busy_po,  (m_phase != 0));
            check_output("cmp_valid", bus.valid_po, m_valid);
            check_output("cmp_id",    bus.id_po,    m_id);
            check_output("cmp_sum",   bus.sum_po,   m_sum);
            check_output("cmp_carry", bus.carry_po, m_carry);
        end
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt0"},  bus.gnt0_po,  0);
        check_output({tag, "_gnt1"},  bus.gnt1_po,  0);
        check_output({tag, "_busy"},  bus.busy_po,  0);
        check_output({tag, "_valid"}, bus.valid_po, 0);
        check_output({tag, "_id"},    bus.id_po,    0);
        check_output({tag, "_sum"},   bus.sum_po,   0);
        check_output({tag, "_carry"}, bus.carry_po, 0);
    endtask

    // One isolated request with immediate ack; checks grant, result and release.
    task automatic apply_stimulus(input bit r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] exp_sum, input bit exp_carry);
        bus.ack_pi = 1'b1;
        if (r) begin
            bus.req1_pi = 1'b1; bus.a1_pi = a; bus.b1_pi = b;
        end else begin
            bus.req0_pi = 1'b1; bus.a0_pi = a; bus.b0_pi = b;
        end
        @(negedge clk);
        check_output("single_gnt0", bus.gnt0_po, !r);
        check_output("single_gnt1", bus.gnt1_po, r);
        check_output("single_busy", bus.busy_po, 1);
        bus.req0_pi = 1'b0;
        bus.req1_pi = 1'b0;
        @(negedge clk);
        check_output("single_valid", bus.valid_po, 1);
        check_output("single_sum",   bus.sum_po,   exp_sum);
        check_output("single_carry", bus.carry_po, exp_carry);
        check_output("single_id",    bus.id_po,    r);
        check_output("single_gnt_off", {bus.gnt0_po, bus.gnt1_po}, 0);
        @(negedge clk);
        check_output("single_valid_drop", bus.valid_po, 0);
        check_output("single_busy_drop",  bus.busy_po,  0);
    endtask

    task automatic new_operands(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
        a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        b = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
    endtask

    initial begin
        bus.req0_pi = 1'b1; bus.a0_pi = 8'd1;  bus.b0_pi = 8'd2;
        bus.req1_pi = 1'b1; bus.a1_pi = 8'd10; bus.b1_pi = 8'd20;
        bus.ack_pi  = 1'b1;
        rst_n = 1'b0;

        // Reset held two cycles with both requests high.
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_first_gnt0", bus.gnt0_po, 1);
        check_output("rst_first_gnt1", bus.gnt1_po, 0);
        bus.req0_pi = 1'b0;
        bus.req1_pi = 1'b0;
        @(negedge clk);
        check_output("rst_first_sum", bus.sum_po, 8'd3);
        check_output("rst_first_id",  bus.id_po,  0);
        @(negedge clk);

        // Single requests, including overflow boundaries.
        apply_stimulus(1'b0, 8'h3C, 8'h42, 8'h7E, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h80, 8'h80, 8'h00, 1'b1);

        // Contention: both held, last served was 1, so grants go 0,1,0,1.
        bus.req0_pi = 1'b1; bus.a0_pi = 8'd1;  bus.b0_pi = 8'd2;
        bus.req1_pi = 1'b1; bus.a1_pi = 8'd10; bus.b1_pi = 8'd20;
        bus.ack_pi  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("cont_gnt0", bus.gnt0_po, (k % 2) == 0);
            check_output("cont_gnt1", bus.gnt1_po, (k % 2) == 1);
            @(negedge clk);
            check_output("cont_gnt_pulse", {bus.gnt0_po, bus.gnt1_po}, 0);
            check_output("cont_valid", bus.valid_po, 1);
            check_output("cont_id",    bus.id_po,    k % 2);
            check_output("cont_sum",   bus.sum_po,   ((k % 2) == 1) ? 30 : 3);
            @(negedge clk);
            check_output("cont_valid_drop", bus.valid_po, 0);
            if (k == 3) begin
                bus.req0_pi = 1'b0;
                bus.req1_pi = 1'b0;
            end
        end
        @(negedge clk);

        // Backpressure: result must hold while ack is low and req1 toggles.
        bus.req0_pi = 1'b1; bus.a0_pi = 8'd5; bus.b0_pi = 8'd7;
        bus.ack_pi  = 1'b0;
        @(negedge clk);
        check_output("bp_gnt0", bus.gnt0_po, 1);
        bus.req0_pi = 1'b0;
        @(negedge clk);
        check_output("bp_valid_first", bus.valid_po, 1);
        check_output("bp_sum_first",   bus.sum_po,   8'h0C);
        for (int i = 0; i < 5; i++) begin
            bus.req1_pi = ~bus.req1_pi;
            bus.a1_pi   = 8'($urandom);
            bus.b1_pi   = 8'($urandom);
            @(negedge clk);
            check_output("bp_valid", bus.valid_po, 1);
            check_output("bp_sum",   bus.sum_po,   8'h0C);
            check_output("bp_id",    bus.id_po,    0);
            check_output("bp_carry", bus.carry_po, 0);
            check_output("bp_gnt1",  bus.gnt1_po,  0);
        end
        bus.req1_pi = 1'b1; bus.a1_pi = 8'h11; bus.b1_pi = 8'h22;
        bus.ack_pi  = 1'b1;
        @(negedge clk);
        check_output("bp_release_valid", bus.valid_po, 0);
        check_output("bp_release_gnt1",  bus.gnt1_po,  0);
        @(negedge clk);
        check_output("bp_next_gnt1", bus.gnt1_po, 1);
        bus.req1_pi = 1'b0;
        @(negedge clk);
        check_output("bp_next_sum", bus.sum_po, 8'h33);
        check_output("bp_next_id",  bus.id_po,  1);
        @(negedge clk);

        // Reset while in CALC: the operation vanishes.
        bus.req0_pi = 1'b1; bus.a0_pi = 8'hF0; bus.b0_pi = 8'h20;
        @(negedge clk);
        check_output("midrst_gnt0", bus.gnt0_po, 1);
        bus.req0_pi = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midrst_no_valid", bus.valid_po, 0);
        @(negedge clk);
        check_output("midrst_still_no_valid", bus.valid_po, 0);

        // Random traffic obeying the requester protocol, with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            bus.ack_pi = 1'($urandom_range(0, 1));
            if (bus.req0_pi) begin
                if (bus.gnt0_po) begin
                    bus.req0_pi = 1'($urandom_range(0, 1));
                    if (bus.req0_pi) new_operands(bus.a0_pi, bus.b0_pi);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req0_pi = 1'b1;
                new_operands(bus.a0_pi, bus.b0_pi);
            end
            if (bus.req1_pi) begin
                if (bus.gnt1_po) begin
                    bus.req1_pi = 1'($urandom_range(0, 1));
                    if (bus.req1_pi) new_operands(bus.a1_pi, bus.b1_pi);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.req1_pi = 1'b1;
                new_operands(bus.a1_pi, bus.b1_pi);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
